// File: rtl/sha3_out_serializer.sv
// Buffers up to DEPTH finished Keccak states and streams each one out as CHUNK_W-bit chunks, LSB first.
// Registered outputs: chunk 0 appears one cycle after the write; outputs hold while stopout is asserted.
module sha3_out_serializer #(
   parameter int STATE_W = 1600,
   parameter int CHUNK_W = 200,
   parameter int TAG_W   = 8,
   parameter int DEPTH   = 2,
   parameter int IX_W    = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pushin,
   input  logic [STATE_W-1:0] din,
   input  logic [TAG_W-1:0]   tagin,
   input  logic [IX_W-1:0]    lastixin,
   output logic               full,
   input  logic               stopout,
   output logic               pushout,
   output logic [CHUNK_W-1:0] dout,
   output logic [IX_W-1:0]    doutix,
   output logic [TAG_W-1:0]   tagout,
   output logic               lastout,
   output logic               ovf
);
   localparam int NCH = STATE_W / CHUNK_W;
   localparam int XW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW  = $clog2(DEPTH + 1);

   if (STATE_W % CHUNK_W != 0) begin : g_bad_chunk
      $error("STATE_W must be a multiple of CHUNK_W");
   end
   if ((2 ** IX_W) < NCH) begin : g_bad_ix
      $error("IX_W too narrow for the number of chunks");
   end

   typedef enum logic [0:0] {IDLE, SEND} state_t;
   state_t state, state_nx;

   logic [CHUNK_W-1:0] mem_dat [DEPTH][NCH];
   logic [TAG_W-1:0]   mem_tag [DEPTH];
   logic [IX_W-1:0]    mem_lix [DEPTH];

   logic [PW-1:0]      wr_ptr, rd_ptr, rd_nxt, wr_nxt;
   logic [CW-1:0]      count, count_nx;
   logic               wr, pop;
   logic [IX_W-1:0]    lix_in;
   logic [CHUNK_W-1:0] dout_nx;
   logic [IX_W-1:0]    ix_nx;
   logic [TAG_W-1:0]   tag_nx;
   logic               last_nx, push_nx;

   assign wr       = pushin && !full;
   assign rd_nxt   = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
   assign wr_nxt   = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
   assign count_nx = count + CW'(wr) - CW'(pop);
   // Digest lengths beyond the state size are clamped to the last chunk.
   assign lix_in   = ({1'b0, lastixin} > (IX_W + 1)'(NCH - 1)) ? IX_W'(NCH - 1) : lastixin;

   always_ff @(posedge clk) begin
      if (wr) begin
         for (int i = 0; i < NCH; i++) begin
            mem_dat[wr_ptr][i] <= din[i*CHUNK_W +: CHUNK_W];
         end
         mem_tag[wr_ptr] <= tagin;
         mem_lix[wr_ptr] <= lix_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      push_nx  = pushout;
      dout_nx  = dout;
      ix_nx    = doutix;
      tag_nx   = tagout;
      last_nx  = lastout;
      case (state)
         IDLE: begin
            if (count != '0) begin
               state_nx = SEND;
               push_nx  = 1'b1;
               ix_nx    = '0;
               dout_nx  = mem_dat[rd_ptr][0];
               tag_nx   = mem_tag[rd_ptr];
               last_nx  = (mem_lix[rd_ptr] == '0);
            end
         end
         SEND: begin
            if (pushout && !stopout) begin
               if (!lastout) begin
                  ix_nx   = doutix + IX_W'(1);
                  dout_nx = mem_dat[rd_ptr][XW'(ix_nx)];
                  last_nx = (ix_nx == mem_lix[rd_ptr]);
               end else begin
                  pop = 1'b1;
                  // Next entry already buffered: start it without a bubble.
                  if (count > CW'(1)) begin
                     ix_nx   = '0;
                     dout_nx = mem_dat[rd_nxt][0];
                     tag_nx  = mem_tag[rd_nxt];
                     last_nx = (mem_lix[rd_nxt] == '0);
                  end else begin
                     state_nx = IDLE;
                     push_nx  = 1'b0;
                     ix_nx    = '0;
                     dout_nx  = '0;
                     tag_nx   = '0;
                     last_nx  = 1'b0;
                  end
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         full    <= 1'b0;
         ovf     <= 1'b0;
         pushout <= 1'b0;
         dout    <= '0;
         doutix  <= '0;
         tagout  <= '0;
         lastout <= 1'b0;
      end else begin
         if (wr)  wr_ptr <= wr_nxt;
         if (pop) rd_ptr <= rd_nxt;
         count   <= count_nx;
         full    <= (count_nx == CW'(DEPTH));
         ovf     <= ovf | (pushin & full);
         pushout <= push_nx;
         dout    <= dout_nx;
         doutix  <= ix_nx;
         tagout  <= tag_nx;
         lastout <= last_nx;
      end
   end
endmodule

// File: tb/tb_sha3_out_serializer.sv
// Randomized and directed bench for sha3_out_serializer against a message-level scoreboard.
module tb_sha3_out_serializer;
   localparam int STATE_W = 1600;
   localparam int CHUNK_W = 200;
   localparam int TAG_W   = 8;
   localparam int DEPTH   = 2;
   localparam int IX_W    = 4;
   localparam int NCH     = STATE_W / CHUNK_W;

   logic               clk = 1'b0;
   logic               reset;
   logic               pushin;
   logic [STATE_W-1:0] din;
   logic [TAG_W-1:0]   tagin;
   logic [IX_W-1:0]    lastixin;
   logic               full;
   logic               stopout;
   logic               pushout;
   logic [CHUNK_W-1:0] dout;
   logic [IX_W-1:0]    doutix;
   logic [TAG_W-1:0]   tagout;
   logic               lastout;
   logic               ovf;

   sha3_out_serializer #(
      .STATE_W(STATE_W), .CHUNK_W(CHUNK_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .IX_W(IX_W)
   ) dut (
      .clk(clk), .reset(reset), .pushin(pushin), .din(din), .tagin(tagin),
      .lastixin(lastixin), .full(full), .stopout(stopout), .pushout(pushout),
      .dout(dout), .doutix(doutix), .tagout(tagout), .lastout(lastout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CHUNK_W-1:0] d;
      logic [IX_W-1:0]    ix;
      logic [TAG_W-1:0]   tag;
      logic               last;
   } beat_t;

   beat_t        q[$];
   int           m_cnt = 0;
   logic         m_ovf = 1'b0;
   int           checks = 0;
   int           failures = 0;
   int           beats = 0;
   logic         was_stall = 1'b0;
   logic [255:0] held;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock: check outputs against the model, advance the model, then take the edge.
   task automatic step();
      beat_t b;
      bit    acc;
      int    lim;
      check("full", 256'(full), 256'(m_cnt == DEPTH));
      check("ovf", 256'(ovf), 256'(m_ovf));
      if (was_stall) check("hold", 256'({pushout, lastout, tagout, doutix, dout}), held);
      if (!pushout) check("idle_zero", 256'({lastout, tagout, doutix, dout}), 256'(0));
      was_stall = pushout && stopout;
      held = 256'({pushout, lastout, tagout, doutix, dout});
      acc = pushin && (m_cnt < DEPTH);
      if (pushin && !acc) m_ovf = 1'b1;
      if (pushout && !stopout) begin
         beats++;
         if (q.size() == 0) check("spurious_beat", 256'(1), 256'(0));
         else begin
            b = q.pop_front();
            check("dout", 256'(dout), 256'(b.d));
            check("doutix", 256'(doutix), 256'(b.ix));
            check("tagout", 256'(tagout), 256'(b.tag));
            check("lastout", 256'(lastout), 256'(b.last));
            if (b.last) m_cnt--;
         end
      end
      if (acc) begin
         lim = (int'(lastixin) > NCH - 1) ? NCH - 1 : int'(lastixin);
         for (int i = 0; i <= lim; i++) begin
            b.d = din[i*CHUNK_W +: CHUNK_W];
            b.ix = IX_W'(i);
            b.tag = tagin;
            b.last = (i == lim);
            q.push_back(b);
         end
         m_cnt++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rand_din();
      for (int w = 0; w < STATE_W / 32; w++) din[w*32 +: 32] = $urandom;
   endtask

   task automatic push(input logic [TAG_W-1:0] t, input logic [IX_W-1:0] lix);
      rand_din();
      pushin = 1'b1; tagin = t; lastixin = lix;
      step();
      pushin = 1'b0;
   endtask

   task automatic wait_ix(input logic [IX_W-1:0] v);
      bit found = 0;
      for (int k = 0; k < 50; k++) begin
         if (pushout && doutix == v) begin found = 1; break; end
         step();
      end
      check("wait_ix_timeout", 256'(found), 256'(1));
   endtask

   task automatic drain();
      stopout = 1'b0; pushin = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (q.size() == 0 && !pushout) break;
         step();
      end
      check("drain_queue", 256'(q.size()), 256'(0));
      check("drain_pushout", 256'(pushout), 256'(0));
   endtask

   task automatic check_all_zero(input string tag);
      check(tag, 256'({full, pushout, dout, doutix, tagout, lastout, ovf}), 256'(0));
   endtask

   initial begin
      int b0;
      logic [CHUNK_W-1:0] sd;
      reset = 1'b1; pushin = 1'b0; din = '0; tagin = '0; lastixin = '0; stopout = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check_all_zero("reset_state");
      reset = 1'b0;
      step();

      // Single message, chunk i holds i+1, with latency check.
      for (int i = 0; i < NCH; i++) din[i*CHUNK_W +: CHUNK_W] = CHUNK_W'(i + 1);
      pushin = 1'b1; tagin = 8'hA5; lastixin = 4'd7;
      b0 = beats;
      step();
      pushin = 1'b0;
      check("lat_edge_k", 256'(pushout), 256'(0));
      step();
      check("lat_edge_k1", 256'(pushout), 256'(1));
      check("first_chunk", 256'(dout), 256'(1));
      drain();
      check("single_beats", 256'(beats - b0), 256'(8));

      // Truncated digest and clamped length.
      b0 = beats; push(8'h11, 4'd1); drain();
      check("trunc_beats", 256'(beats - b0), 256'(2));
      b0 = beats; push(8'h22, 4'd12); drain();
      check("clamp_beats", 256'(beats - b0), 256'(8));

      // Stall at index 4.
      b0 = beats; push(8'h33, 4'd7);
      wait_ix(4'd4);
      stopout = 1'b1; sd = dout;
      for (int k = 0; k < 3; k++) begin
         step();
         check("stall_ix", 256'(doutix), 256'(4));
         check("stall_dout", 256'(dout), 256'(sd));
         check("stall_tag", 256'(tagout), 256'(8'h33));
      end
      stopout = 1'b0;
      step();
      check("after_stall_ix", 256'(doutix), 256'(5));
      drain();
      check("stall_beats", 256'(beats - b0), 256'(8));

      // Three pushes while stalled: third dropped, then two messages with no gap.
      stopout = 1'b1;
      push(8'h41, 4'd7); push(8'h42, 4'd7); push(8'h43, 4'd7);
      check("b2b_full", 256'(full), 256'(1));
      check("b2b_ovf", 256'(ovf), 256'(1));
      stopout = 1'b0;
      b0 = beats;
      for (int k = 0; k < 16; k++) begin
         check("b2b_nogap", 256'(pushout), 256'(1));
         step();
      end
      check("b2b_beats", 256'(beats - b0), 256'(16));
      drain();

      // Reset mid-stream with a second message queued.
      push(8'h51, 4'd7); push(8'h52, 4'd7);
      wait_ix(4'd3);
      reset = 1'b1;
      #1;
      check_all_zero("midreset_async");
      q.delete(); m_cnt = 0; m_ovf = 1'b0; was_stall = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check_all_zero("midreset_held");
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         check("post_reset_quiet", 256'(pushout), 256'(0));
         step();
      end

      // Random traffic.
      for (int k = 0; k < 1500; k++) begin
         pushin = ($urandom_range(0, 2) == 0);
         stopout = ($urandom_range(0, 3) == 0);
         tagin = TAG_W'($urandom);
         lastixin = IX_W'($urandom_range(0, 15));
         rand_din();
         step();
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
